mpc_dense_constraint_gemv_row: RTL and testbench

MPC_DENSE_CONSTRAINT_GEMV_ROW -- requirements
Module: mpc_dense_constraint_gemv_row

---
 rtl/mpc_dense_constraint_gemv_row.sv | 144 ++++++++++++++
 tb/tb_mpc_dense_constraint_gemv_row.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mpc_dense_constraint_gemv_row.sv
// Dense constraint GEMV: temp[i] = sat21(floor(sum_j G[i][j]*x[j] / 2^FRAC)), one row-major
// read per cycle, one accumulate per cycle, one row written after its last product.
module mpc_dense_constraint_gemv_row #(
    parameter int ROWS = 6,
    parameter int COLS = 4,
    parameter int FRAC = 14
) (
    input  logic               ap_clk,
    input  logic               ap_rst,
    input  logic               ap_start,
    output logic               ap_done,
    output logic               ap_idle,
    output logic               ap_ready,
    output logic [4:0]         G_V_address0,
    output logic               G_V_ce0,
    input  logic signed [17:0] G_V_q0,
    output logic [1:0]         x_V_address0,
    output logic               x_V_ce0,
    input  logic signed [20:0] x_V_q0,
    output logic [2:0]         temp_V_address0,
    output logic               temp_V_ce0,
    output logic               temp_V_we0,
    output logic signed [20:0] temp_V_d0
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [4:0] LAST_N = 5'(ROWS * COLS - 1);
    localparam logic [1:0] LAST_J = 2'(COLS - 1);
    localparam logic signed [40:0] SAT_MAX = 41'sd1048575;
    localparam logic signed [40:0] SAT_MIN = -41'sd1048576;

    state_t r_state;
    state_t w_next;

    logic [4:0]         r_n;
    logic [1:0]         r_j;
    logic [2:0]         r_i;
    logic               r_drainCnt;
    logic               r_vld;
    logic [1:0]         r_vldJ;
    logic [2:0]         r_vldI;
    logic signed [40:0] r_acc;
    logic               r_we;
    logic [2:0]         r_wrRow;

    logic signed [38:0] w_prod;
    logic signed [40:0] w_prodExt;
    logic signed [40:0] w_shift;

    assign w_prod    = G_V_q0 * x_V_q0;
    assign w_prodExt = {{2{w_prod[38]}}, w_prod};
    assign w_shift   = r_acc >>> FRAC;

    always_comb begin
        w_next   = r_state;
        ap_idle  = 1'b0;
        ap_done  = 1'b0;
        ap_ready = 1'b0;
        G_V_ce0  = 1'b0;
        x_V_ce0  = 1'b0;
        case (r_state)
            IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) w_next = RUN;
            end
            RUN: begin
                G_V_ce0 = 1'b1;
                x_V_ce0 = 1'b1;
                if (r_n == LAST_N) w_next = DRAIN;
            end
            DRAIN: begin
                if (r_drainCnt) w_next = DONE;
            end
            DONE: begin
                ap_done  = 1'b1;
                ap_ready = 1'b1;
                w_next   = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Row result is read straight off the accumulator while it still holds the finished row.
    always_comb begin
        if (w_shift > SAT_MAX)
            temp_V_d0 = 21'h0FFFFF;
        else if (w_shift < SAT_MIN)
            temp_V_d0 = 21'h100000;
        else
            temp_V_d0 = w_shift[20:0];
    end

    assign G_V_address0    = r_n;
    assign x_V_address0    = r_j;
    assign temp_V_address0 = r_wrRow;
    assign temp_V_ce0      = r_we;
    assign temp_V_we0      = r_we;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state    <= IDLE;
            r_n        <= '0;
            r_j        <= '0;
            r_i        <= '0;
            r_drainCnt <= 1'b0;
            r_vld      <= 1'b0;
            r_vldJ     <= '0;
            r_vldI     <= '0;
            r_acc      <= '0;
            r_we       <= 1'b0;
            r_wrRow    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == RUN) begin
                if (r_n == LAST_N) begin
                    r_n <= '0;
                    r_j <= '0;
                    r_i <= '0;
                end else begin
                    r_n <= r_n + 5'd1;
                    if (r_j == LAST_J) begin
                        r_j <= '0;
                        r_i <= r_i + 3'd1;
                    end else begin
                        r_j <= r_j + 2'd1;
                    end
                end
            end
            r_drainCnt <= (r_state == DRAIN) ? ~r_drainCnt : 1'b0;

            // Read data returns one cycle after issue; carry its (i, j) alongside.
            r_vld  <= (r_state == RUN);
            r_vldJ <= r_j;
            r_vldI <= r_i;
            if (r_vld)
                r_acc <= (r_vldJ == 2'd0) ? w_prodExt : r_acc + w_prodExt;
            r_we <= r_vld && (r_vldJ == LAST_J);
            if (r_vld && (r_vldJ == LAST_J))
                r_wrRow <= r_vldI;
        end
    end

endmodule

// File: tb/tb_mpc_dense_constraint_gemv_row.sv
// Scoreboard bench for mpc_dense_constraint_gemv_row: G/x ROM models with one-cycle latency,
// expected rows from an integer reference model, and a negedge monitor checking timing and data.
module tb_mpc_dense_constraint_gemv_row;

    localparam int ROWS = 6;
    localparam int COLS = 4;
    localparam int FRAC = 14;

    logic               ap_clk = 1'b0;
    logic               ap_rst = 1'b1;
    logic               ap_start = 1'b0;
    logic               ap_done, ap_idle, ap_ready;
    logic [4:0]         G_V_address0;
    logic               G_V_ce0;
    logic signed [17:0] G_V_q0 = '0;
    logic [1:0]         x_V_address0;
    logic               x_V_ce0;
    logic signed [20:0] x_V_q0 = '0;
    logic [2:0]         temp_V_address0;
    logic               temp_V_ce0, temp_V_we0;
    logic signed [20:0] temp_V_d0;

    mpc_dense_constraint_gemv_row #(.ROWS(ROWS), .COLS(COLS), .FRAC(FRAC)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
        .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
        .G_V_address0(G_V_address0), .G_V_ce0(G_V_ce0), .G_V_q0(G_V_q0),
        .x_V_address0(x_V_address0), .x_V_ce0(x_V_ce0), .x_V_q0(x_V_q0),
        .temp_V_address0(temp_V_address0), .temp_V_ce0(temp_V_ce0),
        .temp_V_we0(temp_V_we0), .temp_V_d0(temp_V_d0)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        int                 addr;
        logic signed [20:0] data;
    } exp_t;

    logic signed [17:0] gMem [ROWS*COLS];
    logic signed [20:0] xMem [COLS];
    exp_t sbq [$];

    int cyc = 0;
    int startCyc = 0;
    bit runActive = 1'b0;
    int doneCount = 0;
    int checkCount = 0;
    int passCount = 0;

    // ROM models: registered read, data valid the cycle after ce0
    always @(posedge ap_clk) begin
        cyc <= cyc + 1;
        if (G_V_ce0) G_V_q0 <= gMem[G_V_address0];
        if (x_V_ce0) x_V_q0 <= xMem[x_V_address0];
    end

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checkCount++;
        if (act == exp) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: exact integer dot product, floor division by 2^FRAC, clamp to 21 bits
    function automatic logic signed [20:0] refRow(input int i);
        longint s, q, den;
        s = 0;
        den = longint'(1) << FRAC;
        for (int j = 0; j < COLS; j++)
            s += longint'(gMem[i*COLS + j]) * longint'(xMem[j]);
        q = s / den;
        if (s < 0 && (s % den) != 0) q = q - 1;
        if (q > 1048575) q = 1048575;
        if (q < -1048576) q = -1048576;
        return 21'(q);
    endfunction

    task automatic pushExpected();
        exp_t e;
        for (int i = 0; i < ROWS; i++) begin
            e.addr = i;
            e.data = refRow(i);
            sbq.push_back(e);
        end
    endtask

    // Monitor: timing expectations relative to the accepted start, data from the scoreboard
    always @(negedge ap_clk) begin
        int rel;
        bit expCe, expWe, expDone;
        exp_t e;
        if (!ap_rst) begin
            if (ap_done) doneCount++;
            if (runActive) begin
                rel = cyc - startCyc;
                expCe = (rel >= 1 && rel <= 24);
                expWe = (rel >= 6 && rel <= 26 && ((rel - 6) % 4) == 0);
                expDone = (rel == 27);
                checkOutput("G_ce0", G_V_ce0, expCe);
                checkOutput("x_ce0", x_V_ce0, expCe);
                if (expCe) begin
                    checkOutput("G_addr", G_V_address0, rel - 1);
                    checkOutput("x_addr", x_V_address0, (rel - 1) % COLS);
                end
                checkOutput("ap_idle", ap_idle, !(rel >= 1 && rel <= 27));
                checkOutput("ap_done", ap_done, expDone);
                checkOutput("ap_ready", ap_ready, expDone);
                checkOutput("temp_we0", temp_V_we0, expWe);
            end else begin
                checkOutput("idle_we0", temp_V_we0, 0);
                checkOutput("idle_done", ap_done, 0);
                checkOutput("idle_ce0", G_V_ce0, 0);
            end
            checkOutput("temp_ce_eq_we", temp_V_ce0, temp_V_we0);
            if (temp_V_we0) begin
                if (sbq.size() == 0) begin
                    checkOutput("unexpected_write", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    checkOutput("temp_addr", temp_V_address0, e.addr);
                    checkOutput("temp_data", temp_V_d0, e.data);
                end
            end
        end
    end

    task automatic waitDone(input int target);
        int guard = 0;
        while (doneCount < target && guard < 100) begin
            @(posedge ap_clk);
            guard++;
        end
        if (doneCount < target) checkOutput("done_timeout", doneCount, target);
    endtask

    // One run (or two back-to-back with ap_start held high) on the current memories
    task automatic applyStimulus(input bit hold);
        int target;
        pushExpected();
        if (hold) pushExpected();
        @(posedge ap_clk); #1;
        ap_start = 1'b1;
        startCyc = cyc;
        runActive = 1'b1;
        target = doneCount + 1;
        @(posedge ap_clk); #1;
        if (!hold) ap_start = 1'b0;
        waitDone(target);
        if (hold) begin
            #1;
            startCyc = cyc;
            @(posedge ap_clk); #1;
            ap_start = 1'b0;
            waitDone(target + 1);
        end
        @(posedge ap_clk); #1;
        checkOutput("sb_drained", sbq.size(), 0);
        runActive = 1'b0;
        sbq.delete();
    endtask

    task automatic clearMem();
        for (int n = 0; n < ROWS*COLS; n++) gMem[n] = '0;
        for (int j = 0; j < COLS; j++) xMem[j] = '0;
    endtask

    task automatic randomMem(input bit moderate);
        int v;
        for (int n = 0; n < ROWS*COLS; n++) begin
            if (moderate) v = int'($urandom_range(0, 40000)) - 20000;
            else v = int'($urandom);
            gMem[n] = 18'(v);
        end
        for (int j = 0; j < COLS; j++) begin
            if (moderate) v = int'($urandom_range(0, 100000)) - 50000;
            else v = int'($urandom);
            xMem[j] = 21'(v);
        end
    endtask

    initial begin
        clearMem();
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        checkOutput("rst_idle", ap_idle, 1);
        checkOutput("rst_done", ap_done, 0);
        checkOutput("rst_ready", ap_ready, 0);
        checkOutput("rst_gce", G_V_ce0, 0);
        checkOutput("rst_we", temp_V_we0, 0);
        checkOutput("rst_gaddr", G_V_address0, 0);
        checkOutput("rst_taddr", temp_V_address0, 0);
        checkOutput("rst_d0", temp_V_d0, 0);
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;

        // Identity on the first four rows
        clearMem();
        for (int i = 0; i < 4; i++) gMem[i*COLS + i] = 18'sd16384;
        xMem[0] = 21'sd100; xMem[1] = -21'sd200; xMem[2] = 21'sd300; xMem[3] = -21'sd400;
        applyStimulus(1'b0);

        // Positive and negative saturation
        for (int n = 0; n < ROWS*COLS; n++) gMem[n] = 18'sd131071;
        for (int j = 0; j < COLS; j++) xMem[j] = 21'sd1048575;
        applyStimulus(1'b0);
        for (int n = 0; n < ROWS*COLS; n++) gMem[n] = 18'h20000;
        applyStimulus(1'b0);

        // Floor rounding of tiny products
        clearMem();
        gMem[0] = 18'sd1; xMem[0] = -21'sd1;
        applyStimulus(1'b0);
        xMem[0] = 21'sd1;
        applyStimulus(1'b0);

        for (int k = 0; k < 6; k++) begin
            randomMem(k % 2 == 0);
            applyStimulus(1'b0);
        end

        // Reset in the middle of a run: rows 0 and 1 written, then nothing
        randomMem(1'b1);
        pushExpected();
        @(posedge ap_clk); #1;
        ap_start = 1'b1;
        startCyc = cyc;
        runActive = 1'b1;
        @(posedge ap_clk); #1;
        ap_start = 1'b0;
        repeat (11) @(posedge ap_clk);
        #1;
        ap_rst = 1'b1;
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        runActive = 1'b0;
        checkOutput("abort_rows_written", ROWS - sbq.size(), 2);
        sbq.delete();
        @(negedge ap_clk);
        checkOutput("abort_idle", ap_idle, 1);
        repeat (20) @(posedge ap_clk);
        randomMem(1'b1);
        applyStimulus(1'b0);

        // ap_start held high: back-to-back runs with identical results
        randomMem(1'b1);
        applyStimulus(1'b1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
